// File: rtl/bpsk_frame_pkg.sv
// Shared types and constants for the BPSK frame decoder.
// WAVELENGTH mirrors the demodulator's samples-per-symbol setting.
package bpsk_frame_pkg;

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

    localparam int         BYTE_W        = 8;
    localparam logic [7:0] SYNC_WORD_DEF = 8'hA7;
    localparam int         MAX_LEN_DEF   = 32;
    localparam int         WAVELENGTH    = 16;

    function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] a,
                                                   input logic [BYTE_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/bit_shift_collector.sv
// MSB-first 8-bit shifter. byte_done is combinational with the 8th strobe and
// byte_out already carries that bit, so the caller can act in the same cycle.
module bit_shift_collector
    import bpsk_frame_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              bit_in,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_done
);

    logic [BYTE_W-1:0] shreg;
    logic [2:0]        cnt;

    assign byte_out  = {shreg[BYTE_W-2:0], bit_in};
    assign byte_done = enable && (cnt == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (enable) begin
            shreg <= byte_out;
            cnt   <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/bpsk_frame_decoder.sv
// Sync hunt with phase-ambiguity resolution, then length/payload/checksum
// framing into a valid/ready byte stream with ok/err status pulses.
module bpsk_frame_decoder
    import bpsk_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int         MAX_LEN   = MAX_LEN_DEF,
    parameter int         TIMEOUT   = 16 * WAVELENGTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              frame_start,
    output logic              frame_last,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              inverted
);

    localparam int                TW         = $clog2(TIMEOUT + 1);
    localparam logic [BYTE_W-1:0] MAX_LEN_B  = BYTE_W'(MAX_LEN);
    localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [BYTE_W-1:0] hunt_sr, hunt_next;
    logic [BYTE_W-1:0] len, csum, idx;
    logic [TW-1:0]     tmo_cnt;

    logic              col_en, col_clear, byte_done;
    logic [BYTE_W-1:0] col_byte;

    logic ok_n, err_n, load, lock, lock_inv, go_hunt, timeout, overrun, is_last;

    assign col_en    = bit_valid && (state != HUNT);
    assign hunt_next = {hunt_sr[BYTE_W-2:0], bit_in};
    assign is_last   = (idx == len - 8'd1);

    bit_shift_collector u_col (
        .clk       (clk),
        .reset     (reset),
        .clear     (col_clear),
        .enable    (col_en),
        .bit_in    (bit_in ^ inverted),
        .byte_out  (col_byte),
        .byte_done (byte_done)
    );

    always_comb begin
        state_n  = state;
        ok_n     = 1'b0;
        err_n    = 1'b0;
        load     = 1'b0;
        lock     = 1'b0;
        lock_inv = 1'b0;
        timeout  = (state != HUNT) && !bit_valid && (tmo_cnt == TMO_LAST);
        overrun  = byte_done && byte_valid && !byte_ready;

        case (state)
            HUNT: begin
                if (bit_valid && hunt_next == SYNC_WORD) begin
                    state_n = LEN;
                    lock    = 1'b1;
                end else if (bit_valid && hunt_next == ~SYNC_WORD) begin
                    state_n  = LEN;
                    lock     = 1'b1;
                    lock_inv = 1'b1;
                end
            end
            LEN: begin
                if (byte_done) begin
                    if (col_byte > MAX_LEN_B) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end else if (col_byte == '0) begin
                        state_n = CHECK;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_done) begin
                    if (overrun) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end else begin
                        load = 1'b1;
                        if (is_last) state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byte_done) begin
                    ok_n    = (col_byte == csum);
                    err_n   = (col_byte != csum);
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase

        // Timeout outranks anything the bit logic decided this cycle.
        if (timeout) begin
            state_n = HUNT;
            ok_n    = 1'b0;
            err_n   = 1'b1;
            load    = 1'b0;
        end

        go_hunt   = (state_n == HUNT) && (state != HUNT);
        col_clear = lock || go_hunt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            hunt_sr     <= '0;
            inverted    <= 1'b0;
            len         <= '0;
            csum        <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state     <= state_n;
            frame_ok  <= ok_n;
            frame_err <= err_n;

            if (go_hunt)
                hunt_sr <= '0;
            else if (state == HUNT && bit_valid)
                hunt_sr <= hunt_next;

            if (go_hunt)
                inverted <= 1'b0;
            else if (lock)
                inverted <= lock_inv;

            if (state == LEN && byte_done) begin
                len  <= col_byte;
                csum <= col_byte;
                idx  <= '0;
            end else if (load) begin
                csum <= csum_add(csum, col_byte);
                idx  <= idx + 8'd1;
            end

            if (state_n == HUNT || bit_valid)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            // A new load wins over a same-cycle accept of the previous byte.
            if (load) begin
                byte_data   <= col_byte;
                byte_valid  <= 1'b1;
                frame_start <= (idx == '0);
                frame_last  <= is_last;
            end else if (byte_valid && byte_ready) begin
                byte_valid  <= 1'b0;
                frame_start <= 1'b0;
                frame_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bpsk_frame_decoder.sv
// Directed frames into the decoder; a monitor checks accepted bytes and status
// pulses against expectations queued by the stimulus process.
module tb_bpsk_frame_decoder;

    localparam int TIMEOUT = 16 * bpsk_frame_pkg::WAVELENGTH;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       l;
        logic       i;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid, frame_start, frame_last, frame_ok, frame_err, inverted;

    int   checks = 0;
    int   failures = 0;
    exp_t byte_q[$];
    bit   ev_q[$];

    bpsk_frame_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .inverted    (inverted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (byte_valid && byte_ready) begin
                exp_t e;
                checks++;
                if (byte_q.size() == 0) begin
                    failures++;
                    $display("FAIL byte_unexpected: got %h s=%b l=%b, none expected",
                             byte_data, frame_start, frame_last);
                end else begin
                    e = byte_q.pop_front();
                    if ({byte_data, frame_start, frame_last, inverted} !== e) begin
                        failures++;
                        $display("FAIL byte: got %h s=%b l=%b inv=%b, expected %h s=%b l=%b inv=%b",
                                 byte_data, frame_start, frame_last, inverted, e.d, e.s, e.l, e.i);
                    end
                end
            end
            if (frame_ok || frame_err) begin
                checks++;
                if (frame_ok && frame_err) begin
                    failures++;
                    $display("FAIL status_both: ok=1 err=1, expected only one");
                end else if (ev_q.size() == 0) begin
                    failures++;
                    $display("FAIL status_unexpected: ok=%b err=%b, none expected", frame_ok, frame_err);
                end else begin
                    bit ok_exp;
                    ok_exp = ev_q.pop_front();
                    if (frame_ok !== ok_exp) begin
                        failures++;
                        $display("FAIL status: got ok=%b err=%b, expected ok=%b", frame_ok, frame_err, ok_exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic exp_byte(input logic [7:0] d, input logic s, input logic l, input logic i);
        exp_t e;
        e = '{d: d, s: s, l: l, i: i};
        byte_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drained(input string name);
        chk({name, "_bytes_left"}, byte_q.size(), 0);
        chk({name, "_events_left"}, ev_q.size(), 0);
    endtask

    initial begin
        idle(2);
        chk("reset_byte_valid", byte_valid, 0);
        chk("reset_byte_data", byte_data, 0);
        chk("reset_flags", {frame_start, frame_last, frame_ok, frame_err, inverted}, 0);
        reset = 1'b1;
        idle(2);

        // normal frame
        exp_byte(8'h11, 1, 0, 0); exp_byte(8'h22, 0, 0, 0); exp_byte(8'h33, 0, 1, 0);
        ev_q.push_back(1'b1);
        send_byte(8'hA7); send_byte(8'h03);
        chk("normal_locked_inv", inverted, 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        idle(10);
        drained("normal");

        // inverted lock
        exp_byte(8'h11, 1, 0, 1); exp_byte(8'h22, 0, 0, 1); exp_byte(8'h33, 0, 1, 1);
        ev_q.push_back(1'b1);
        send_byte(8'h58); send_byte(8'hFC);
        chk("inv_locked", inverted, 1);
        send_byte(8'hEE); send_byte(8'hDD); send_byte(8'hCC); send_byte(8'h96);
        idle(10);
        drained("inverted");
        chk("inv_cleared_in_hunt", inverted, 0);

        // bad checksum
        exp_byte(8'h10, 1, 0, 0); exp_byte(8'h20, 0, 1, 0);
        ev_q.push_back(1'b0);
        send_byte(8'hA7); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
        idle(10);
        drained("badsum");

        // illegal length, then zero length
        ev_q.push_back(1'b0);
        send_byte(8'hA7); send_byte(8'h28);
        idle(10);
        drained("badlen");
        ev_q.push_back(1'b1);
        send_byte(8'hA7); send_byte(8'h00); send_byte(8'h00);
        idle(10);
        drained("zerolen");

        // overrun with sink stalled
        byte_ready = 1'b0;
        ev_q.push_back(1'b0);
        send_byte(8'hA7); send_byte(8'h02); send_byte(8'h55); send_byte(8'h66);
        idle(10);
        chk("overrun_held_valid", byte_valid, 1);
        chk("overrun_held_data", byte_data, 8'h55);
        chk("overrun_held_flags", {frame_start, frame_last}, 2'b10);
        exp_byte(8'h55, 1, 0, 0);
        byte_ready = 1'b1;
        idle(5);
        chk("overrun_popped_once", byte_valid, 0);
        drained("overrun");

        // timeout mid-payload, then relock
        ev_q.push_back(1'b0);
        send_byte(8'hA7); send_byte(8'h01);
        idle(TIMEOUT + 10);
        drained("timeout");
        ev_q.push_back(1'b1);
        send_byte(8'hA7); send_byte(8'h00); send_byte(8'h00);
        idle(10);
        drained("after_timeout");

        // async reset mid-payload with a byte held
        byte_ready = 1'b0;
        send_byte(8'hA7); send_byte(8'h03); send_byte(8'h11);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        chk("pre_reset_valid", byte_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_valid", byte_valid, 0);
        chk("async_reset_data", byte_data, 0);
        chk("async_reset_flags", {frame_start, frame_last, frame_ok, frame_err, inverted}, 0);
        idle(2);
        reset = 1'b1;
        byte_ready = 1'b1;
        idle(2);
        exp_byte(8'h11, 1, 0, 0); exp_byte(8'h22, 0, 0, 0); exp_byte(8'h33, 0, 1, 0);
        ev_q.push_back(1'b1);
        send_byte(8'hA7); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        idle(10);
        drained("relock");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
